// File: rtl/pll_lock_sequencer.sv
// ============================================================================
//  Module      : pll_lock_sequencer
//  Description : PLL reset/lock sequencer. Pulses the PLL reset, waits for a
//                stable synchronized lock (with timeout and retry), holds the
//                core in reset for a hold-off, then releases it. Lock loss or
//                a relock request re-sequences the PLL.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module pll_lock_sequencer #(
   parameter int unsigned RST_CYCLES   = 16,
   parameter int unsigned LOCK_STABLE  = 1024,
   parameter int unsigned LOCK_TIMEOUT = 65536,
   parameter int unsigned SYS_HOLD     = 256,
   parameter int unsigned CNT_W        = 17
) (
   input  logic       refclk,
   input  logic       rst_n,
   input  logic       locked,
   input  logic       relock_req,
   output logic       pll_rst,
   output logic       sys_rst_n,
   output logic [1:0] state,
   output logic [3:0] retry_cnt,
   output logic [7:0] loss_cnt
);

   typedef enum logic [1:0] {
      S_PLLRST   = 2'd0,
      S_WAITLOCK = 2'd1,
      S_HOLD     = 2'd2,
      S_RUN      = 2'd3
   } state_t;

   // Terminal counts: a phase of N cycles ends when its counter reads N-1.
   localparam logic [CNT_W-1:0] c_RST_LAST    = CNT_W'(RST_CYCLES - 1);
   localparam logic [CNT_W-1:0] c_STABLE_LAST = CNT_W'(LOCK_STABLE - 1);
   localparam logic [CNT_W-1:0] c_TMO_LAST    = CNT_W'(LOCK_TIMEOUT - 1);
   localparam logic [CNT_W-1:0] c_HOLD_LAST   = CNT_W'(SYS_HOLD - 1);

   logic             r_sync1;
   logic             r_lock_s;
   state_t           r_state;
   state_t           w_state_nxt;
   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] w_cnt_nxt;
   logic [CNT_W-1:0] r_tmo;
   logic [CNT_W-1:0] w_tmo_nxt;
   logic [3:0]       r_retry;
   logic [7:0]       r_loss;
   logic             w_retry_inc;
   logic             w_loss_inc;
   logic             r_pll_rst;
   logic             r_sys_rst_n;

   // Two-flop synchronizer: the only consumer of the asynchronous lock input.
   always_ff @(posedge refclk or negedge rst_n) begin
      if (!rst_n) begin
         r_sync1  <= 1'b0;
         r_lock_s <= 1'b0;
      end else begin
         r_sync1  <= locked;
         r_lock_s <= r_sync1;
      end
   end

   // Next-state, counter and event decode for the sequencer.
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_tmo_nxt   = r_tmo;
      w_retry_inc = 1'b0;
      w_loss_inc  = 1'b0;
      case (r_state)
         S_PLLRST: begin
            if (r_cnt == c_RST_LAST) begin
               w_state_nxt = S_WAITLOCK;
               w_cnt_nxt   = '0;
               w_tmo_nxt   = '0;
            end else begin
               w_cnt_nxt = r_cnt + 1'b1;
            end
         end
         S_WAITLOCK: begin
            w_tmo_nxt = r_tmo + 1'b1;
            w_cnt_nxt = r_lock_s ? (r_cnt + 1'b1) : '0;
            if (r_lock_s && (r_cnt == c_STABLE_LAST)) begin
               w_state_nxt = S_HOLD;
               w_cnt_nxt   = '0;
            end else if (r_tmo == c_TMO_LAST) begin
               w_state_nxt = S_PLLRST;
               w_cnt_nxt   = '0;
               w_retry_inc = 1'b1;
            end
         end
         S_HOLD: begin
            w_cnt_nxt = r_cnt + 1'b1;
            if (!r_lock_s) begin
               // Loss during hold-off is not counted as a RUN lock loss.
               w_state_nxt = S_PLLRST;
               w_cnt_nxt   = '0;
            end else if (r_cnt == c_HOLD_LAST) begin
               w_state_nxt = S_RUN;
               w_cnt_nxt   = '0;
            end
         end
         S_RUN: begin
            if (!r_lock_s) begin
               w_state_nxt = S_PLLRST;
               w_cnt_nxt   = '0;
               w_loss_inc  = 1'b1;
            end
         end
         default: begin
            w_state_nxt = S_PLLRST;
            w_cnt_nxt   = '0;
         end
      endcase
      // A relock request overrides the transition but not the event counts;
      // it is ignored while the PLL reset pulse is already in progress.
      if (relock_req && (r_state != S_PLLRST)) begin
         w_state_nxt = S_PLLRST;
         w_cnt_nxt   = '0;
      end
   end

   // State, counters and registered output decode.
   always_ff @(posedge refclk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= S_PLLRST;
         r_cnt       <= '0;
         r_tmo       <= '0;
         r_retry     <= '0;
         r_loss      <= '0;
         r_pll_rst   <= 1'b1;
         r_sys_rst_n <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_cnt       <= w_cnt_nxt;
         r_tmo       <= w_tmo_nxt;
         r_pll_rst   <= (w_state_nxt == S_PLLRST);
         r_sys_rst_n <= (w_state_nxt == S_RUN);
         if (w_retry_inc && (r_retry != 4'hF)) begin
            r_retry <= r_retry + 4'd1;
         end
         if (w_loss_inc && (r_loss != 8'hFF)) begin
            r_loss <= r_loss + 8'd1;
         end
      end
   end

   assign pll_rst   = r_pll_rst;
   assign sys_rst_n = r_sys_rst_n;
   assign state     = r_state;
   assign retry_cnt = r_retry;
   assign loss_cnt  = r_loss;

endmodule

`default_nettype wire

// File: tb/tb_pll_lock_sequencer.sv
// ============================================================================
//  Module      : tb_pll_lock_sequencer
//  Description : Directed scoreboard bench for pll_lock_sequencer with
//                RST_CYCLES=4, LOCK_STABLE=8, LOCK_TIMEOUT=64, SYS_HOLD=16.
//  Revision    : 1.1  direct asynchronous reset checks
// ============================================================================
`default_nettype none

module tb_pll_lock_sequencer;

    localparam logic [1:0] c_PLLRST = 2'd0;
    localparam logic [1:0] c_WAIT   = 2'd1;
    localparam logic [1:0] c_HOLD   = 2'd2;
    localparam logic [1:0] c_RUN    = 2'd3;

    logic       refclk;
    logic       rst_n;
    logic       locked;
    logic       relock_req;
    logic       pll_rst;
    logic       sys_rst_n;
    logic [1:0] state;
    logic [3:0] retry_cnt;
    logic [7:0] loss_cnt;

    pll_lock_sequencer #(
        .RST_CYCLES  (4),
        .LOCK_STABLE (8),
        .LOCK_TIMEOUT(64),
        .SYS_HOLD    (16),
        .CNT_W       (17)
    ) dut (
        .refclk    (refclk),
        .rst_n     (rst_n),
        .locked    (locked),
        .relock_req(relock_req),
        .pll_rst   (pll_rst),
        .sys_rst_n (sys_rst_n),
        .state     (state),
        .retry_cnt (retry_cnt),
        .loss_cnt  (loss_cnt)
    );

    // Expected snapshot {state, pll_rst, sys_rst_n, retry_cnt, loss_cnt}
    // due at the falling edge after rising edge number 'at'.
    typedef struct {
        int          at;
        string       nm;
        logic [15:0] exp;
    } exp_t;

    exp_t sb[$];
    int   cyc    = 0;
    int   n_cmp  = 0;
    int   n_bad  = 0;

    initial begin
        refclk = 1'b0;
        forever #5 refclk = ~refclk;
    end

    // Rising-edge count; stimulus reads it 1 time unit after each edge.
    initial begin
        forever begin
            @(posedge refclk);
            cyc++;
        end
    end

    // Monitor: compares due scoreboard entries on the falling edge.
    initial begin
        exp_t        e;
        logic [15:0] got;
        forever begin
            @(negedge refclk);
            got = {state, pll_rst, sys_rst_n, retry_cnt, loss_cnt};
            while (sb.size() > 0 && sb[0].at <= cyc) begin
                e = sb.pop_front();
                n_cmp++;
                if (e.at != cyc || got !== e.exp) begin
                    n_bad++;
                    $display("FAIL %s @cycle %0d (due %0d): got st=%0d pll_rst=%0b sys_rst_n=%0b retry=%0d loss=%0d, want st=%0d pll_rst=%0b sys_rst_n=%0b retry=%0d loss=%0d",
                             e.nm, cyc, e.at, got[15:14], got[13], got[12], got[11:8], got[7:0],
                             e.exp[15:14], e.exp[13], e.exp[12], e.exp[11:8], e.exp[7:0]);
                end
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge refclk);
        #1;
    endtask

    task automatic chk(input int at, input string nm, input logic [1:0] st,
                       input logic pr, input logic sr, input int rc, input int lc);
        exp_t e;
        e.at  = at;
        e.nm  = nm;
        e.exp = {st, pr, sr, 4'(rc), 8'(lc)};
        sb.push_back(e);
    endtask

    initial begin
        int b;
        rst_n      = 1'b0;
        locked     = 1'b0;
        relock_req = 1'b0;

        // Reset state while rst_n is held low with the clock running.
        step(3);
        chk(cyc,     "reset_hold0", c_PLLRST, 1, 0, 0, 0);
        chk(cyc + 1, "reset_hold1", c_PLLRST, 1, 0, 0, 0);
        step(2);

        // Clean start: pll_rst high for 4 edges, locked raised 10 edges later.
        rst_n = 1'b1;
        b = cyc;
        chk(b + 1, "rel_edge0",  c_PLLRST, 1, 0, 0, 0);
        chk(b + 3, "rel_edge2",  c_PLLRST, 1, 0, 0, 0);
        chk(b + 4, "rel_wait",   c_WAIT,   0, 0, 0, 0);
        step(10);
        locked = 1'b1;
        b = cyc;
        chk(b + 9,  "clean_wait_end", c_WAIT, 0, 0, 0, 0);
        chk(b + 10, "clean_hold",     c_HOLD, 0, 0, 0, 0);
        chk(b + 25, "clean_hold_end", c_HOLD, 0, 0, 0, 0);
        chk(b + 26, "clean_run",      c_RUN,  0, 1, 0, 0);
        step(30);

        // Relock in RUN, a relock during PLLRST (ignored), relock in HOLD.
        b = cyc;
        chk(b + 1,  "rlk_run",       c_PLLRST, 1, 0, 0, 0);
        chk(b + 4,  "rlk_pllrst_4",  c_PLLRST, 1, 0, 0, 0);
        chk(b + 5,  "rlk_ignored",   c_WAIT,   0, 0, 0, 0);
        chk(b + 12, "rlk_wait_end",  c_WAIT,   0, 0, 0, 0);
        chk(b + 13, "rlk_hold",      c_HOLD,   0, 0, 0, 0);
        chk(b + 15, "rlk_hold_pr",   c_PLLRST, 1, 0, 0, 0);
        chk(b + 18, "rlk_pllrst_4b", c_PLLRST, 1, 0, 0, 0);
        chk(b + 19, "rlk_wait2",     c_WAIT,   0, 0, 0, 0);
        chk(b + 27, "rlk_hold2",     c_HOLD,   0, 0, 0, 0);
        chk(b + 42, "rlk_hold2_end", c_HOLD,   0, 0, 0, 0);
        chk(b + 43, "rlk_run2",      c_RUN,    0, 1, 0, 0);
        relock_req = 1'b1;
        step(1);
        relock_req = 1'b0;
        step(3);
        relock_req = 1'b1;      // sampled on the last PLLRST edge
        step(1);
        relock_req = 1'b0;
        step(9);
        relock_req = 1'b1;      // sampled in HOLD
        step(1);
        relock_req = 1'b0;
        step(30);

        // Lock loss in RUN, locked restored right away.
        b = cyc;
        locked = 1'b0;
        chk(b + 2,  "loss_still_run", c_RUN,    0, 1, 0, 0);
        chk(b + 3,  "loss_pllrst",    c_PLLRST, 1, 0, 0, 1);
        chk(b + 6,  "loss_pllrst_4",  c_PLLRST, 1, 0, 0, 1);
        chk(b + 7,  "loss_wait",      c_WAIT,   0, 0, 0, 1);
        chk(b + 15, "loss_hold",      c_HOLD,   0, 0, 0, 1);
        chk(b + 31, "loss_run",       c_RUN,    0, 1, 0, 1);
        step(1);
        locked = 1'b1;
        step(34);

        // Relock coinciding with lock loss in RUN: loss still counted.
        b = cyc;
        locked = 1'b0;
        chk(b + 2,  "coin_run",    c_RUN,    0, 1, 0, 1);
        chk(b + 3,  "coin_pllrst", c_PLLRST, 1, 0, 0, 2);
        chk(b + 7,  "coin_wait",   c_WAIT,   0, 0, 0, 2);
        chk(b + 15, "coin_hold",   c_HOLD,   0, 0, 0, 2);
        chk(b + 31, "coin_run2",   c_RUN,    0, 1, 0, 2);
        step(2);
        relock_req = 1'b1;
        step(1);
        relock_req = 1'b0;
        locked     = 1'b1;
        step(33);

        // Glitch in WAITLOCK: 5 high, 1 low, then high restarts the count.
        b = cyc;
        locked = 1'b0;
        chk(b + 3,  "glt_pllrst",    c_PLLRST, 1, 0, 0, 3);
        chk(b + 7,  "glt_wait",      c_WAIT,   0, 0, 0, 3);
        chk(b + 18, "glt_restarted", c_WAIT,   0, 0, 0, 3);
        chk(b + 23, "glt_wait_end",  c_WAIT,   0, 0, 0, 3);
        chk(b + 24, "glt_hold",      c_HOLD,   0, 0, 0, 3);
        chk(b + 39, "glt_hold_end",  c_HOLD,   0, 0, 0, 3);
        chk(b + 40, "glt_run",       c_RUN,    0, 1, 0, 3);
        step(8);
        locked = 1'b1;
        step(5);
        locked = 1'b0;
        step(1);
        locked = 1'b1;
        step(28);

        // Asynchronous reset from RUN clears everything before the next edge.
        chk(cyc, "async_rst_run", c_PLLRST, 1, 0, 0, 0);
        rst_n  = 1'b0;
        locked = 1'b0;
        #1;
        n_cmp++;
        if (state !== c_PLLRST || pll_rst !== 1'b1 || sys_rst_n !== 1'b0 ||
            retry_cnt !== 4'd0 || loss_cnt !== 8'd0) begin
            n_bad++;
            $display("FAIL async_rst_run_direct: st=%0d pll_rst=%0b sys_rst_n=%0b retry=%0d loss=%0d",
                     state, pll_rst, sys_rst_n, retry_cnt, loss_cnt);
        end
        step(2);

        // No lock: 68-edge retry period, then reset mid-WAITLOCK at retry=3.
        rst_n = 1'b1;
        b = cyc;
        chk(b + 4,   "nl_wait",      c_WAIT,   0, 0, 0, 0);
        chk(b + 67,  "nl_wait_end",  c_WAIT,   0, 0, 0, 0);
        chk(b + 68,  "nl_retry1",    c_PLLRST, 1, 0, 1, 0);
        chk(b + 72,  "nl_wait1",     c_WAIT,   0, 0, 1, 0);
        chk(b + 136, "nl_retry2",    c_PLLRST, 1, 0, 2, 0);
        chk(b + 204, "nl_retry3",    c_PLLRST, 1, 0, 3, 0);
        chk(b + 219, "nl_wait3",     c_WAIT,   0, 0, 3, 0);
        chk(b + 220, "rst_mid_wait", c_PLLRST, 1, 0, 0, 0);
        step(220);
        #2;
        rst_n = 1'b0;           // between edges; checked before the next edge
        #1;
        n_cmp++;
        if (state !== c_PLLRST || pll_rst !== 1'b1 || sys_rst_n !== 1'b0 ||
            retry_cnt !== 4'd0 || loss_cnt !== 8'd0) begin
            n_bad++;
            $display("FAIL rst_mid_wait_direct: st=%0d pll_rst=%0b sys_rst_n=%0b retry=%0d loss=%0d",
                     state, pll_rst, sys_rst_n, retry_cnt, loss_cnt);
        end
        step(2);

        // Retry counter saturation at 15.
        rst_n = 1'b1;
        b = cyc;
        chk(b + 68,   "sat_retry1",   c_PLLRST, 1, 0, 1, 0);
        chk(b + 1020, "sat_retry15",  c_PLLRST, 1, 0, 15, 0);
        chk(b + 1024, "sat_wait15",   c_WAIT,   0, 0, 15, 0);
        chk(b + 1088, "sat_retry16",  c_PLLRST, 1, 0, 15, 0);
        chk(b + 1092, "sat_wait16",   c_WAIT,   0, 0, 15, 0);
        step(1095);

        // Drain with a bounded wait; anything left over is a failure.
        for (int i = 0; i < 50 && sb.size() > 0; i++) step(1);
        while (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            n_cmp++;
            n_bad++;
            $display("FAIL %s: never compared (due cycle %0d, now %0d)", e.nm, e.at, cyc);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        if (n_bad == 0 && n_cmp > 0) begin
            $display("*** TEST PASSED ***");
        end else begin
            $display("*** TEST FAILED ***");
        end
        $finish;
    end

endmodule

`default_nettype wire
